dom_shared_mul_gf2n_hs: RTL
===========================

Name: dom_shared_mul_gf2n_hs

Overview:
Parametrised successor of the GF(4) DOM shared multiplier. Computes a d+1-share masked product Q = X*Y over GF(2^N), with N and the field polynomial as parameters. Selectable DOM-indep or DOM-dep (blinded Y) mode, optional output register, and a valid/ready handshake with backpressure. It sits in the masked S-box datapath, between inversion stages, wherever a stallable shared field multiply is needed.

Parameters:
N, 4, field width in bits; legal values 2, 4, 8.
POLY, 4'b0011, low N bits of the irreducible polynomial (x^N implicit); 4'b0011 = x^4+x+1.
SHARES, 2, number of shares, >=2.
DEPENDENT, 0, 0 = DOM-indep; 1 = DOM-dep, Y blinded with B before use.
OUT_REG, 1, 1 = Q registered (latency 2); 0 = Q combinational from stage-1 registers (latency 1).

Ports:
ClkxCI  in  1  clock, rising edge.
RstxBI  in  1  reset; synchronous, active-low.
InValidxSI  in  1  input transaction valid.
InReadyxSO  out  1  block can accept an input this cycle.
_XxDI  in  N*SHARES  X shares; share i is bits [i*N +: N].
_YxDI  in  N*SHARES  Y shares, same packing.
_ZxDI  in  N*SHARES*(SHARES-1)/2  fresh remask randomness; pair k is bits [k*N +: N].
_BxDI  in  N*SHARES  blinding randomness; ignored when DEPENDENT=0.
OutValidxSO  out  1  _QxDO holds a valid result.
OutReadyxSI  in  1  consumer accepts the result.
_QxDO  out  N*SHARES  product shares.

Behaviour:
- Pipeline enable: adv = ~OutValidxSO | OutReadyxSI, extended per stage (a stage advances when it is empty or the next stage advances). InReadyxSO = stage-1 advance.
- Input fires on InValidxSI & InReadyxSO. X, Y, Z and B are sampled only on a fire. Randomness is consumed exactly once per fired transaction.
- Stage 1, DEPENDENT=0, registers:
  - X_i.
  - Y_i.
  - Cross terms C_ij = X_i*Y_j ^ Z_k for every i!=j. Pair (i,j) with i<j uses the same Z_k for C_ij and C_ji; k enumerates pairs lexicographically.
- Stage 1, DEPENDENT=1, registers:
  - X_i.
  - BY_i = Y_i ^ B_i.
  - Cross terms computed as above with B in place of Y.
- Stage-1 output, DEPENDENT=0: Q_i = X_i*Y_i ^ XOR_j C_ij.
- Stage-1 output, DEPENDENT=1: Q_i = X_i*(XOR_k BY_k) ^ X_i*B_i ^ XOR_j C_ij. X_i*B_i uses registered B_i.
- Only registered values feed multipliers whose result crosses domains.
- OUT_REG=1: Q_i is registered at stage 2. OUT_REG=0: Q_i is driven from stage-1 registers.
- Latency from fire to OutValidxSO is 1+OUT_REG cycles when OutReadyxSI is held high. Throughput is 1 result per cycle.
- Stall: while OutValidxSO & ~OutReadyxSI, _QxDO and all stage registers hold. No data is lost or duplicated. Input is accepted only into an empty or advancing stage.
- Simultaneous fire and output accept: both take effect; the pipeline shifts.
- Reset (RstxBI=0 at an edge) clears all valid bits and zeroes every data register. After reset: OutValidxSO=0, _QxDO=0, InReadyxSO=1. Reset mid-transaction drops in-flight data.
- Correctness: XOR of the Q shares equals the GF(2^N) product of XOR(X) and XOR(Y) mod POLY, for every Z and B value.
- Field multiply: shift-and-add, reduce by POLY. Purely combinational.

Decomposition:
- Shared package or include holds:
  - pair-count function npairs(s) = s*(s-1)/2;
  - pair-index function idx(i,j);
  - default POLY constants per N: 2'b11, 4'b0011, 8'h1B.
- One sub-module, gf2n_mul_poly (params N, POLY; inputs AxDI, BxDI; output QxDO), instantiated per product term.

Test Plan:
1. N=4, SHARES=2, DEPENDENT=0, OUT_REG=1, XOR(X)=0x3, XOR(Y)=0x5, random Z, OutReadyxSI=1 -> OutValidxSO rises 2 cycles after fire; XOR(Q)=0xF.
2. Same configuration with DEPENDENT=1 and random B: XOR(X)=0x8, XOR(Y)=0x2 -> XOR(Q)=0x3. Repeat 1000 random vectors against a reference model; zero mismatches.
3. Backpressure: stream 4 transactions with OutReadyxSI low for 3 cycles mid-stream -> _QxDO stable while stalled, InReadyxSO=0 once the pipe is full, results in order, none lost.
4. OUT_REG=0, SHARES=3, N=8, POLY=8'h1B: XOR(X)=0x57, XOR(Y)=0x83 -> XOR(Q)=0xC1 one cycle after fire.
5. Assert RstxBI=0 for one cycle with 2 transactions in flight -> next cycle OutValidxSO=0, _QxDO=0, InReadyxSO=1; the next fired transaction completes normally.
6. Randomness independence: fix X and Y, sweep Z over all 16 values with N=4, SHARES=2 -> share Q_0 takes varying values, XOR(Q) remains constant.

Source files
------------

// File: rtl/dom_shared_mul_gf2n_hs_pkg.sv
// Shared definitions for the DOM shared GF(2^N) multiplier.
//   npairs(s)        : number of unordered share pairs, s*(s-1)/2
//   idx(i, j, s)     : lexicographic index of pair (i,j), i<j, among s shares
//   default_poly(n)  : low n bits of the default irreducible polynomial for
//                      GF(2^n), n in {2, 4, 8}
package dom_shared_mul_gf2n_hs_pkg;

  localparam logic [1:0] POLY_GF4   = 2'b11;     // x^2+x+1
  localparam logic [3:0] POLY_GF16  = 4'b0011;   // x^4+x+1
  localparam logic [7:0] POLY_GF256 = 8'h1B;     // x^8+x^4+x^3+x+1

  function automatic int npairs(input int s);
    return (s * (s - 1)) / 2;
  endfunction

  // Pairs are enumerated (0,1),(0,2)..(0,s-1),(1,2)..; row i starts after
  // the s-1 + s-2 + .. + s-i pairs of the previous rows.
  function automatic int idx(input int i, input int j, input int s);
    return i * s - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic logic [7:0] default_poly(input int n);
    case (n)
      2:       return {6'd0, POLY_GF4};
      4:       return {4'd0, POLY_GF16};
      default: return POLY_GF256;
    endcase
  endfunction

endpackage

// File: rtl/dom_shared_mul_gf2n_hs_gf2n_mul_poly.sv
// Combinational GF(2^N) multiplier, shift-and-add with reduction by POLY
// after every shift of the multiplicand.
//   AxDI [N-1:0] : operand A
//   BxDI [N-1:0] : operand B
//   QxDO [N-1:0] : A*B mod (x^N + POLY)
module gf2n_mul_poly
  import dom_shared_mul_gf2n_hs_pkg::*;
#(
  parameter int          N    = 4,
  parameter logic [N-1:0] POLY = N'(default_poly(N))
) (
  input  logic [N-1:0] AxDI,
  input  logic [N-1:0] BxDI,
  output logic [N-1:0] QxDO
);

  always_comb begin
    logic [N-1:0] v_acc;
    logic [N-1:0] v_a;
    v_acc = '0;
    v_a   = AxDI;
    for (int i = 0; i < N; i++) begin
      if (BxDI[i]) v_acc = v_acc ^ v_a;
      // multiply the running multiplicand by x, folding x^N back via POLY
      v_a = (v_a << 1) ^ (v_a[N-1] ? POLY : '0);
    end
    QxDO = v_acc;
  end

endmodule

// File: rtl/dom_shared_mul_gf2n_hs.sv
// Domain-oriented-masking shared multiplier over GF(2^N) with a valid/ready
// handshake. XOR of the Q shares equals XOR(X) * XOR(Y) in GF(2^N).
//   ClkxCI, RstxBI            : clock, synchronous active-low reset
//   InValidxSI / InReadyxSO   : input handshake; X, Y, Z, B sampled on fire
//   _XxDI, _YxDI [N*SHARES]   : operand shares, share i at [i*N +: N]
//   _ZxDI [N*npairs(SHARES)]  : fresh remask randomness, pair k at [k*N +: N]
//   _BxDI [N*SHARES]          : blinding randomness (DEPENDENT=1 only)
//   OutValidxSO / OutReadyxSI : output handshake
//   _QxDO [N*SHARES]          : product shares
module dom_shared_mul_gf2n_hs
  import dom_shared_mul_gf2n_hs_pkg::*;
#(
  parameter int           N         = 4,
  parameter logic [N-1:0] POLY      = N'(default_poly(N)),
  parameter int           SHARES    = 2,
  parameter bit           DEPENDENT = 1'b0,
  parameter bit           OUT_REG   = 1'b1
) (
  input  logic                          ClkxCI,
  input  logic                          RstxBI,
  input  logic                          InValidxSI,
  output logic                          InReadyxSO,
  input  logic [N*SHARES-1:0]           _XxDI,
  input  logic [N*SHARES-1:0]           _YxDI,
  input  logic [N*npairs(SHARES)-1:0]   _ZxDI,
  input  logic [N*SHARES-1:0]           _BxDI,
  output logic                          OutValidxSO,
  input  logic                          OutReadyxSI,
  output logic [N*SHARES-1:0]           _QxDO
);

  localparam int NP = npairs(SHARES);

  logic         w_fire;
  logic         w_adv_p1;
  logic         w_adv_out;
  logic         w_vld_out;

  logic [N-1:0] w_x      [SHARES];
  logic [N-1:0] w_y      [SHARES];
  logic [N-1:0] w_b      [SHARES];
  logic [N-1:0] w_yop    [SHARES];
  logic [N-1:0] w_ystore [SHARES];
  logic [N-1:0] w_z      [NP];
  logic [N-1:0] w_c      [SHARES][SHARES];

  logic         r_vld_p1;
  logic [N-1:0] r_x_p1   [SHARES];
  logic [N-1:0] r_y_p1   [SHARES];
  logic [N-1:0] r_b_p1   [SHARES];
  logic [N-1:0] r_c_p1   [SHARES][SHARES];

  logic [N-1:0] w_ysum;
  logic [N-1:0] w_inop   [SHARES];
  logic [N-1:0] w_qin    [SHARES];
  logic [N-1:0] w_qxb    [SHARES];
  logic [N-1:0] w_q_p1   [SHARES];
  logic [N-1:0] w_qout   [SHARES];

  // ---- stage 0: input unpacking and cross-domain products ----
  // In DOM-dep mode the cross terms use the blinding B instead of Y, and
  // stage 1 keeps only the blinded Y^B.
  always_comb begin
    for (int i = 0; i < SHARES; i++) begin
      w_x[i]      = _XxDI[i*N +: N];
      w_y[i]      = _YxDI[i*N +: N];
      w_b[i]      = _BxDI[i*N +: N];
      w_yop[i]    = DEPENDENT ? w_b[i] : w_y[i];
      w_ystore[i] = DEPENDENT ? (w_y[i] ^ w_b[i]) : w_y[i];
    end
    for (int k = 0; k < NP; k++) begin
      w_z[k] = _ZxDI[k*N +: N];
    end
  end

  for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
    for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
      if (gi == gj) begin : g_diag
        // diagonal kept as zero so the stage-1 fold can XOR a full row
        assign w_c[gi][gj] = '0;
      end else begin : g_cross
        // C_ij and C_ji share one Z so the masks cancel in XOR(Q)
        localparam int K = (gi < gj) ? idx(gi, gj, SHARES) : idx(gj, gi, SHARES);
        logic [N-1:0] w_prod;
        gf2n_mul_poly #(.N(N), .POLY(POLY)) u_cross (
          .AxDI (w_x[gi]),
          .BxDI (w_yop[gj]),
          .QxDO (w_prod)
        );
        assign w_c[gi][gj] = w_prod ^ w_z[K];
      end
    end
  end

  assign w_fire     = InValidxSI & w_adv_p1;
  assign InReadyxSO = w_adv_p1;

  // ---- stage 1 registers ----
  always_ff @(posedge ClkxCI) begin
    if (!RstxBI) begin
      r_vld_p1 <= 1'b0;
      for (int i = 0; i < SHARES; i++) begin
        r_x_p1[i] <= '0;
        r_y_p1[i] <= '0;
        r_b_p1[i] <= '0;
        for (int j = 0; j < SHARES; j++) r_c_p1[i][j] <= '0;
      end
    end else if (w_adv_p1) begin
      r_vld_p1 <= w_fire;
      if (w_fire) begin
        for (int i = 0; i < SHARES; i++) begin
          r_x_p1[i] <= w_x[i];
          r_y_p1[i] <= w_ystore[i];
          r_b_p1[i] <= DEPENDENT ? w_b[i] : '0;
          for (int j = 0; j < SHARES; j++) r_c_p1[i][j] <= w_c[i][j];
        end
      end
    end
  end

  // Inner-domain terms, fed only from stage-1 registers. In DOM-dep mode
  // X_i*(Y^B) over all shares is corrected by X_i*B_i; in DOM-indep mode
  // r_b_p1 stays zero and that product vanishes.
  always_comb begin
    w_ysum = '0;
    for (int k = 0; k < SHARES; k++) w_ysum = w_ysum ^ r_y_p1[k];
    for (int i = 0; i < SHARES; i++) begin
      w_inop[i] = DEPENDENT ? w_ysum : r_y_p1[i];
    end
  end

  for (genvar gi = 0; gi < SHARES; gi++) begin : g_inner
    gf2n_mul_poly #(.N(N), .POLY(POLY)) u_in (
      .AxDI (r_x_p1[gi]),
      .BxDI (w_inop[gi]),
      .QxDO (w_qin[gi])
    );
    gf2n_mul_poly #(.N(N), .POLY(POLY)) u_xb (
      .AxDI (r_x_p1[gi]),
      .BxDI (r_b_p1[gi]),
      .QxDO (w_qxb[gi])
    );
  end

  always_comb begin
    for (int i = 0; i < SHARES; i++) begin
      w_q_p1[i] = w_qin[i] ^ w_qxb[i];
      for (int j = 0; j < SHARES; j++) w_q_p1[i] = w_q_p1[i] ^ r_c_p1[i][j];
    end
  end

  assign w_adv_out = ~w_vld_out | OutReadyxSI;

  // ---- stage 2: optional output register ----
  if (OUT_REG) begin : g_oreg
    logic         r_vld_p2;
    logic [N-1:0] r_q_p2 [SHARES];

    assign w_vld_out = r_vld_p2;
    assign w_adv_p1  = ~r_vld_p1 | w_adv_out;

    always_ff @(posedge ClkxCI) begin
      if (!RstxBI) begin
        r_vld_p2 <= 1'b0;
        for (int i = 0; i < SHARES; i++) r_q_p2[i] <= '0;
      end else if (w_adv_out) begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) begin
          for (int i = 0; i < SHARES; i++) r_q_p2[i] <= w_q_p1[i];
        end
      end
    end

    always_comb begin
      for (int i = 0; i < SHARES; i++) w_qout[i] = r_q_p2[i];
    end
  end else begin : g_ocomb
    // stage 1 is the output stage, so its advance is the output advance
    assign w_vld_out = r_vld_p1;
    assign w_adv_p1  = w_adv_out;

    always_comb begin
      for (int i = 0; i < SHARES; i++) w_qout[i] = w_q_p1[i];
    end
  end

  assign OutValidxSO = w_vld_out;

  always_comb begin
    _QxDO = '0;
    for (int i = 0; i < SHARES; i++) _QxDO[i*N +: N] = w_qout[i];
  end

endmodule
